// File: rtl/mul_pkg.sv
// Shared multiply/divide definitions: stage limits, slot record and overflow check.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

package mul_pkg;

   localparam int MUL_MIN_STAGES = 2;
   localparam int MUL_MAX_STAGES = 8;
   // Widest operand the shared overflow check is sized for.
   localparam int MUL_MAX_W      = 64;
   localparam int MUL_DEF_W      = `REG_SIZE;
   localparam int MUL_DEF_TAG_W  = 5;

   // Slot record at the default widths; blocks with other widths mirror this layout.
   typedef struct packed {
      logic                       vld;
      logic                       sgn;
      logic [MUL_DEF_TAG_W-1:0]   dst;
      logic [2*MUL_DEF_W-1:0]     prod;
   } mul_slot_t;

   // Overflow of a 2*w-bit product truncated to w bits. Unsigned: any high bit set.
   // Signed: high half is not a pure sign extension of bit w-1.
   function automatic logic mul_ovf(input logic [2*MUL_MAX_W-1:0] prod,
                                    input int w,
                                    input logic is_signed);
      logic sb;
      logic ovf;
      sb  = 1'b0;
      ovf = 1'b0;
      for (int i = 0; i < MUL_MAX_W; i++) begin
         if (i == w - 1) sb = prod[i];
      end
      for (int i = 0; i < 2*MUL_MAX_W; i++) begin
         if (i >= w && i < 2*w) begin
            if (is_signed ? (prod[i] != sb) : prod[i]) ovf = 1'b1;
         end
      end
      return ovf;
   endfunction

endpackage

// File: rtl/mul_stage_reg.sv
// One pipeline slot: valid bit plus payload, held on stall, valid cleared on flush.
// Latency: 1 cycle.
// Backpressure: stall freezes the slot; flush wins over stall and drops the valid bit.
module mul_stage_reg #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          vld_i,
   input  logic [DW-1:0] dat_i,
   output logic          vld_o,
   output logic [DW-1:0] dat_o
);

   logic          vld_q, vld_d;
   logic [DW-1:0] dat_q, dat_d;

   // Next state: flush kills the entry, stall holds, otherwise take the upstream slot.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (flush) begin
         vld_d = 1'b0;
      end else if (!stall) begin
         vld_d = vld_i;
         dat_d = dat_i;
      end
   end

   // Slot register; reset also clears payload so the outputs read zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/mul_pipe.sv
// Multi-cycle multiply pipeline (STAGES slots); optional overflow flag under MUL_OVF_EN.
// Latency: STAGES cycles from presentation to out_valid; one op per cycle throughput.
// Backpressure: stall freezes every slot and deasserts in_ready; flush drops all ops.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module mul_pipe
   import mul_pkg::*;
#(
   parameter int WIDTH  = `REG_SIZE,
   parameter int STAGES = 5,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
   input  logic [TAG_W-1:0] in_dst,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_overflow,
   output logic [TAG_W-1:0] out_dst,
   output logic             busy
);

   if (STAGES < MUL_MIN_STAGES || STAGES > MUL_MAX_STAGES) begin : g_bad_stages
      $error("mul_pipe: STAGES must be within 2..8");
   end
   if (WIDTH < 1 || WIDTH > MUL_MAX_W) begin : g_bad_width
      $error("mul_pipe: WIDTH out of range");
   end

   // Without overflow detection only the low half of the product is ever observed.
`ifdef MUL_OVF_EN
   localparam int PW = 2*WIDTH;
`else
   localparam int PW = WIDTH;
`endif

   typedef struct packed {
      logic             sgn;
      logic [TAG_W-1:0] dst;
      logic [PW-1:0]    prod;
   } slot_dat_t;

   localparam int DW = $bits(slot_dat_t);

   logic [2*WIDTH-1:0] a_ext, b_ext, prod_full;
   slot_dat_t          dat_in;
   logic [STAGES-1:0]  vld_s;
   slot_dat_t          dat_s [STAGES];
   slot_dat_t          last;

   // Extend operands to 2*WIDTH so one unsigned multiply yields the exact product in both modes.
   always_comb begin
      a_ext       = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
      b_ext       = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
      prod_full   = a_ext * b_ext;
      dat_in      = '0;
      dat_in.sgn  = in_signed;
      dat_in.dst  = in_dst;
      dat_in.prod = prod_full[PW-1:0];
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_slot
      if (i == 0) begin : g_head
         mul_stage_reg #(.DW(DW)) u_slot (
            .clk   (clk),
            .reset (reset),
            .stall (stall),
            .flush (flush),
            .vld_i (in_valid),
            .dat_i (dat_in),
            .vld_o (vld_s[0]),
            .dat_o (dat_s[0])
         );
      end else begin : g_body
         mul_stage_reg #(.DW(DW)) u_slot (
            .clk   (clk),
            .reset (reset),
            .stall (stall),
            .flush (flush),
            .vld_i (vld_s[i-1]),
            .dat_i (dat_s[i-1]),
            .vld_o (vld_s[i]),
            .dat_o (dat_s[i])
         );
      end
   end

   assign last       = dat_s[STAGES-1];
   assign in_ready   = !stall;
   assign busy       = |vld_s;
   assign out_valid  = vld_s[STAGES-1];
   assign out_result = last.prod[WIDTH-1:0];
   assign out_dst    = last.dst;
   // Flags are qualified by valid so that reset and flushed slots present all-zero outputs.
   assign out_zero   = out_valid && (out_result == '0);

`ifdef MUL_OVF_EN
   assign out_overflow = out_valid &&
                         mul_ovf((2*MUL_MAX_W)'(last.prod), WIDTH, last.sgn);
`else
   logic unused_hi;
   assign unused_hi    = ^{prod_full[2*WIDTH-1:WIDTH], last.sgn};
   assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;

   localparam int WIDTH  = 32;
   localparam int STAGES = 5;
   localparam int TAG_W  = 5;
`ifdef MUL_OVF_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset, in_valid, in_ready, in_signed, stall, flush;
   logic [WIDTH-1:0] in_a, in_b, out_result;
   logic [TAG_W-1:0] in_dst, out_dst;
   logic             out_valid, out_zero, out_overflow, busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_signed    (in_signed),
      .in_dst       (in_dst),
      .stall        (stall),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_result   (out_result),
      .out_zero     (out_zero),
      .out_overflow (out_overflow),
      .out_dst      (out_dst),
      .busy         (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [TAG_W-1:0] d);
      in_a = a; in_b = b; in_signed = s; in_dst = d; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
      in_dst = '0; stall = 1'b0; flush = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset valid: got %0b want 0", out_valid); end
      checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset result: got %0h want 0", out_result); end
      checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL reset zero: got %0b want 0", out_zero); end
      checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL reset ovf: got %0b want 0", out_overflow); end
      checks++; if (out_dst !== 5'd0) begin failures++; $display("FAIL reset dst: got %0d want 0", out_dst); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %0b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset ready: got %0b want 1", in_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_unsigned();
      issue(32'h0001_0000, 32'h0001_0000, 1'b0, 5'd3);
      tick(); tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL unsigned early: got %0b want 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL unsigned valid: got %0b want 1", out_valid); end
      checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL unsigned result: got %0h want 0", out_result); end
      checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL unsigned zero: got %0b want 1", out_zero); end
      checks++; if (out_overflow !== OVF) begin failures++; $display("FAIL unsigned ovf: got %0b want %0b", out_overflow, OVF); end
      checks++; if (out_dst !== 5'd3) begin failures++; $display("FAIL unsigned dst: got %0d want 3", out_dst); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL unsigned single: got %0b want 0", out_valid); end
   endtask

   task automatic test_signed();
      issue(32'hFFFF_FFFE, 32'd3, 1'b1, 5'd7);
      issue(32'hFFFF_FFFE, 32'd3, 1'b0, 5'd8);
      issue(32'h8000_0000, 32'd2, 1'b1, 5'd9);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd10);
      tick();
      // -2 * 3 signed: fits
      checks++; if (out_result !== 32'hFFFF_FFFA) begin failures++; $display("FAIL signed result: got %0h want fffffffa", out_result); end
      checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL signed zero: got %0b want 0", out_zero); end
      checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL signed ovf: got %0b want 0", out_overflow); end
      checks++; if (out_dst !== 5'd7) begin failures++; $display("FAIL signed dst: got %0d want 7", out_dst); end
      tick();
      // same operands unsigned: 0x2_FFFF_FFFA
      checks++; if (out_result !== 32'hFFFF_FFFA) begin failures++; $display("FAIL uns2 result: got %0h want fffffffa", out_result); end
      checks++; if (out_overflow !== OVF) begin failures++; $display("FAIL uns2 ovf: got %0b want %0b", out_overflow, OVF); end
      tick();
      // -2^31 * 2 = -2^32: low half zero, high half all ones -> overflow
      checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL sminx2 zero: got %0b want 1", out_zero); end
      checks++; if (out_overflow !== OVF) begin failures++; $display("FAIL sminx2 ovf: got %0b want %0b", out_overflow, OVF); end
      tick();
      // -1 * -1 = 1
      checks++; if (out_result !== 32'd1) begin failures++; $display("FAIL negneg result: got %0h want 1", out_result); end
      checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL negneg ovf: got %0b want 0", out_overflow); end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 5; i++) begin
         in_a = WIDTH'(i); in_b = WIDTH'(i + 10); in_signed = 1'b0;
         in_dst = TAG_W'(i); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b valid %0d: got %0b want 1", i, out_valid); end
         checks++; if (out_dst !== TAG_W'(i)) begin failures++; $display("FAIL b2b dst %0d: got %0d want %0d", i, out_dst, i); end
         checks++; if (out_result !== WIDTH'(i * (i + 10))) begin failures++; $display("FAIL b2b result %0d: got %0d want %0d", i, out_result, i * (i + 10)); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b tail: got %0b want 0", out_valid); end
   endtask

   task automatic test_stall();
      issue(32'd2, 32'd3, 1'b0, 5'd10);
      issue(32'd4, 32'd5, 1'b0, 5'd11);
      tick(); tick(); tick();
      checks++; if (out_valid !== 1'b1 || out_dst !== 5'd10) begin failures++; $display("FAIL stall pre: got v=%0b d=%0d want v=1 d=10", out_valid, out_dst); end
      stall = 1'b1;
      in_a = 32'd9; in_b = 32'd9; in_dst = 5'd20; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall ready: got %0b want 0", in_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_dst !== 5'd10 || out_result !== 32'd6) begin
            failures++; $display("FAIL stall hold %0d: got v=%0b d=%0d r=%0d want v=1 d=10 r=6", k, out_valid, out_dst, out_result); end
      end
      stall = 1'b0; in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_dst !== 5'd11 || out_result !== 32'd20) begin
         failures++; $display("FAIL stall second: got v=%0b d=%0d r=%0d want v=1 d=11 r=20", out_valid, out_dst, out_result); end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall extra %0d: got %0b want 0", k, out_valid); end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) issue(32'd3, 32'd3, 1'b0, TAG_W'(21 + i));
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush busy pre: got %0b want 1", busy); end
      flush = 1'b1; stall = 1'b1;
      in_a = 32'd5; in_b = 32'd5; in_dst = 5'd25; in_valid = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush busy: got %0b want 0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush valid: got %0b want 0", out_valid); end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush after %0d: got v=%0b b=%0b want 0 0", k, out_valid, busy); end
      end
   endtask

   task automatic test_reset_mid();
      issue(32'd3, 32'd3, 1'b0, 5'd30);
      issue(32'd4, 32'd4, 1'b0, 5'd31);
      tick();
      reset = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_zero !== 1'b0 ||
                    out_overflow !== 1'b0 || out_dst !== 5'd0 || busy !== 1'b0) begin
         failures++; $display("FAIL midreset outs: got v=%0b r=%0h z=%0b o=%0b d=%0d b=%0b want all 0",
                              out_valid, out_result, out_zero, out_overflow, out_dst, busy); end
      reset = 1'b0;
      issue(32'd7, 32'd6, 1'b0, 5'd9);
      tick(); tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset early: got %0b want 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd42 || out_dst !== 5'd9 || out_overflow !== 1'b0) begin
         failures++; $display("FAIL midreset op: got v=%0b r=%0d d=%0d o=%0b want v=1 r=42 d=9 o=0",
                              out_valid, out_result, out_dst, out_overflow); end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset ghost %0d: got %0b want 0", k, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised multi-cycle multiply pipeline for the exec stage. It replaces the hand-written fixed multiply stages with a single block of configurable depth and operand width. Each accepted operation travels through the block as one entry carrying:
- its result,
- zero and overflow flags,
- its destination register tag.

The block supports stall, flush and signed/unsigned modes, and sits between decode/issue and the writeback mux.

## Interface
Parameters:
- WIDTH, `REG_SIZE: operand and result width in bits.
- STAGES, 5: pipeline depth (latency). Legal range 2..8.
- TAG_W, 5: destination register tag width.

Ports (one clock, `clk`; synchronous active-high reset, `reset`):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all valid bits and all outputs.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  combinational, equal to !stall; an op is accepted when in_valid && in_ready.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement multiply, 0 = unsigned.
- in_dst  in  TAG_W  destination register tag.
- stall  in  1  freeze every stage; outputs hold.
- flush  in  1  kill every in-flight op and the op presented this cycle.
- out_valid  out  1  result entry valid.
- out_result  out  WIDTH  low WIDTH bits of the product.
- out_zero  out  1  out_result == 0.
- out_overflow  out  1  product does not fit in WIDTH (see Configuration).
- out_dst  out  TAG_W  tag of the op in the final stage.
- busy  out  1  any stage holds a valid op.

## Operation
Pipeline structure:
- STAGES registered slots, slot 0 through slot STAGES-1.
- Each slot holds valid, signed, dst and a 2*WIDTH-bit product.

Per cycle:
- On acceptance, slot 0 captures the full 2*WIDTH product. Operands are sign-extended when in_signed = 1 and zero-extended otherwise.
- Later slots forward the product unchanged; synthesis may retime the multiplier across them.
- The final slot drives the outputs directly:
  - out_result = product[WIDTH-1:0].
  - out_zero = (out_result == 0), taken from the low half only.
  - out_overflow: unsigned mode, high half nonzero; signed mode, high half not equal to WIDTH copies of product[WIDTH-1].

Stall and flush:
- stall = 1: no slot updates, no op is accepted, and the outputs hold their previous values.
- flush = 1: every valid bit clears on the next edge and the op presented this cycle is dropped. Data fields may retain stale values, but out_valid = 0 qualifies them.

Priority and boundaries:
- Priority is reset > flush > stall > normal advance.
- flush with stall in the same cycle: flush wins and the valid bits clear.
- A bubble (in_valid = 0, no stall) shifts a 0 into slot 0's valid bit.
- Ops leave in issue order; there is no reordering.
- busy = OR of all slot valid bits, registered.

## Timing
- Latency: an op accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES cycles from presentation.
- Throughput: one op per cycle while stall = 0.
- Every stall cycle adds exactly one cycle of latency to every in-flight op.
- Reset values: out_valid = 0, out_result = 0, out_zero = 0, out_overflow = 0, out_dst = 0, busy = 0.
- Reset asserted mid-operation discards every in-flight op; the first op accepted after reset has normal latency.
- in_ready has no register and depends only on stall.

## Configuration
- MUL_OVF_EN defined: overflow detection logic is built and out_overflow behaves as described above.
- MUL_OVF_EN undefined: out_overflow is tied to 0 and slots store only the low WIDTH product bits, halving product storage. out_result and out_zero are unchanged.

## Structure
- Shared package mul_pkg holds:
  - constants MUL_MIN_STAGES = 2 and MUL_MAX_STAGES = 8;
  - the slot record typedef (valid, signed, dst, product);
  - an overflow-check function shared with the divider.
- One natural sub-module, mul_stage_reg: a single slot register with stall hold and flush clear, instantiated STAGES times via generate.
- STAGES outside 2..8 is an elaboration error.

## Test plan
- Unsigned: WIDTH = 32, STAGES = 5, a = 0x0001_0000, b = 0x0001_0000, dst = 3 -> four cycles later out_valid = 1, result = 0, zero = 1, overflow = 1, dst = 3.
- Signed: a = 0xFFFF_FFFE (-2), b = 3, signed = 1 -> result = 0xFFFF_FFFA, zero = 0, overflow = 0. The same operands with signed = 0 -> overflow = 1.
- Back-to-back ops with dst = 1, 2, 3, 4, 5 on consecutive cycles -> out_valid high for five consecutive cycles with dst in order 1..5.
- Stall held for 3 cycles while 2 ops are in flight -> outputs frozen, both ops emerge exactly 3 cycles late, and none is lost or duplicated.
- flush raised together with stall and in_valid while 4 ops are in flight -> next cycle busy = 0 and out_valid = 0; nothing emerges afterwards.
- reset pulsed mid-stream, then a = 7, b = 6 accepted -> all outputs 0 during reset, then result = 42 after STAGES cycles. Rerun with MUL_OVF_EN undefined -> out_overflow stays 0 throughout.
